// File: rtl/fpu_pkg.sv
// Shared field widths, exception bit positions, FSM states and the unpacked operand type
// for the FP32 add/align core.
package fpu_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 25;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned ADD_W  = 1 + EXP_W + MAN_W;

    localparam int unsigned EXC_NAN  = 0;
    localparam int unsigned EXC_PINF = 1;
    localparam int unsigned EXC_NINF = 2;
    localparam int unsigned EXC_INV  = 3;

    localparam logic [4:0] MAX_REM = 5'd25;

    typedef enum logic [1:0] {
        StIdle,
        StAlign,
        StAdd,
        StDone
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [MAN_W-1:0] mant;
        logic             is_zero;
        logic             is_inf;
        logic             is_qnan;
        logic             is_snan;
    } fp_unpacked_t;

    // Anything beyond 25 positions already shifts the whole mantissa out.
    function automatic logic [4:0] clamp_rem(input logic [EXP_W-1:0] diff);
        if (diff > {3'b000, MAX_REM}) begin
            return MAX_REM;
        end
        return diff[4:0];
    endfunction

endpackage

// File: rtl/fpu_unpack.sv
// Combinational FP32 field extraction and classification; denormals are flushed to zero
// so the mantissa carries the hidden bit at position 23 for every non-zero operand.
module fpu_unpack
    import fpu_pkg::*;
(
    input  logic [31:0]      operand,
    output logic             sign,
    output logic [EXP_W-1:0] exponent,
    output logic [MAN_W-1:0] mant,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_qnan,
    output logic             is_snan
);

    logic [FRAC_W-1:0] frac;
    logic              exp_max;
    logic              frac_zero;

    always_comb begin
        sign      = operand[31];
        exponent  = operand[30:23];
        frac      = operand[22:0];
        exp_max   = (exponent == 8'hFF);
        frac_zero = (frac == '0);
        is_zero   = (exponent == 8'h00);
        is_inf    = exp_max && frac_zero;
        is_qnan   = exp_max && !frac_zero && frac[FRAC_W-1];
        is_snan   = exp_max && !frac_zero && !frac[FRAC_W-1];
        mant      = is_zero ? '0 : {2'b01, frac};
    end

endmodule

// File: rtl/fpu_add_align.sv
// FP32 add/sub front end: classify, swap by magnitude, align the smaller mantissa, add.
// Define FPU_ALIGN_BARREL_EN for a single-cycle barrel alignment instead of SHIFT_STEP steps.
module fpu_add_align
    import fpu_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       a_i,
    input  logic [31:0]       b_i,
    input  logic              op_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADD_W-1:0]  add_o,
    output logic [3:0]        exception_o
);

    fp_unpacked_t ua;
    fp_unpacked_t ub;

    fpu_unpack u_unpack_a (
        .operand  (a_i),
        .sign     (ua.sign),
        .exponent (ua.exponent),
        .mant     (ua.mant),
        .is_zero  (ua.is_zero),
        .is_inf   (ua.is_inf),
        .is_qnan  (ua.is_qnan),
        .is_snan  (ua.is_snan)
    );

    fpu_unpack u_unpack_b (
        .operand  (b_i),
        .sign     (ub.sign),
        .exponent (ub.exponent),
        .mant     (ub.mant),
        .is_zero  (ub.is_zero),
        .is_inf   (ub.is_inf),
        .is_qnan  (ub.is_qnan),
        .is_snan  (ub.is_snan)
    );

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [ADD_W-1:0] add_q;
    logic [3:0]       exc_q;
    logic             sign_l_q;
    logic             sign_s_q;
    logic [EXP_W-1:0] exp_l_q;
    logic [MAN_W-1:0] mant_l_q;
    logic [MAN_W-1:0] mant_s_q;
    logic [4:0]       rem_q;

    logic             sign_b_eff;
    logic             a_ge_b;
    logic [EXP_W-1:0] exp_diff;
    logic             special;
    logic [3:0]       exc_special;
    logic [MAN_W-1:0] add_res;

    // Operand classification and L/S selection at the accept boundary.
    always_comb begin
        sign_b_eff = ub.sign ^ op_i;
        a_ge_b     = ub.is_zero ||
                     (!ua.is_zero && ({ua.exponent, ua.mant} >= {ub.exponent, ub.mant}));
        exp_diff   = a_ge_b ? (ua.exponent - ub.exponent) : (ub.exponent - ua.exponent);

        special     = 1'b0;
        exc_special = '0;
        if (ua.is_qnan || ua.is_snan || ub.is_qnan || ub.is_snan) begin
            special              = 1'b1;
            exc_special[EXC_NAN] = 1'b1;
            exc_special[EXC_INV] = ua.is_snan || ub.is_snan;
        end else if (ua.is_inf || ub.is_inf) begin
            special = 1'b1;
            if (ua.is_inf && ub.is_inf && (ua.sign != sign_b_eff)) begin
                exc_special[EXC_NAN] = 1'b1;
                exc_special[EXC_INV] = 1'b1;
            end else if (ua.is_inf ? ua.sign : sign_b_eff) begin
                exc_special[EXC_NINF] = 1'b1;
            end else begin
                exc_special[EXC_PINF] = 1'b1;
            end
        end
    end

    // L >= S in magnitude, so the difference never goes negative.
    always_comb begin
        if (sign_l_q == sign_s_q) begin
            add_res = mant_l_q + mant_s_q;
        end else begin
            add_res = mant_l_q - mant_s_q;
        end
    end

`ifndef FPU_ALIGN_BARREL_EN
    localparam logic [4:0] STEP = 5'(SHIFT_STEP);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            add_q       <= '0;
            exc_q       <= '0;
            sign_l_q    <= 1'b0;
            sign_s_q    <= 1'b0;
            exp_l_q     <= '0;
            mant_l_q    <= '0;
            mant_s_q    <= '0;
            rem_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        sign_l_q   <= a_ge_b ? ua.sign : sign_b_eff;
                        sign_s_q   <= a_ge_b ? sign_b_eff : ua.sign;
                        exp_l_q    <= a_ge_b ? ua.exponent : ub.exponent;
                        mant_l_q   <= a_ge_b ? ua.mant : ub.mant;
                        mant_s_q   <= a_ge_b ? ub.mant : ua.mant;
                        rem_q      <= clamp_rem(exp_diff);
                        if (special) begin
                            exc_q       <= exc_special;
                            add_q       <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            exc_q   <= '0;
                            state_q <= StAlign;
                        end
                    end
                end
                StAlign: begin
`ifdef FPU_ALIGN_BARREL_EN
                    mant_s_q <= mant_s_q >> rem_q;
                    rem_q    <= '0;
                    state_q  <= StAdd;
`else
                    if (rem_q > STEP) begin
                        mant_s_q <= mant_s_q >> SHIFT_STEP;
                        rem_q    <= rem_q - STEP;
                    end else begin
                        mant_s_q <= mant_s_q >> rem_q;
                        rem_q    <= '0;
                        state_q  <= StAdd;
                    end
`endif
                end
                StAdd: begin
                    // Exact zero leaves as +0 with exponent 0 so post-norm passes it through.
                    if (add_res == '0) begin
                        add_q <= '0;
                    end else begin
                        add_q <= {sign_l_q, exp_l_q, add_res};
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign add_o       = add_q;
    assign exception_o = exc_q;

endmodule
